// File: rtl/tl_phase_if.sv
// Signal bundle between the four-approach traffic-light scheduler and its environment.
// The master side drives demand; the slave side (the scheduler) drives lamps and grants.
interface tl_phase_if;
  logic [3:0] req;
  logic [3:0] red;
  logic [3:0] yel;
  logic [3:0] gre;
  logic [3:0] ack;
  logic [1:0] phase;

  modport master (output req, input red, yel, gre, ack, phase);
  modport slave  (input req, output red, yel, gre, ack, phase);
endinterface

// File: rtl/tl_phase_scheduler.sv
// Four-approach traffic-light phase scheduler: round-robin service of latched demand,
// bounded green (min/max), fixed yellow and all-red clearance intervals.
module tl_phase_scheduler #(
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 24,
  parameter int YELLOW    = 4,
  parameter int ALL_RED   = 2
) (
  input  logic       clk,
  input  logic       rst,
  tl_phase_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_ALLRED = 2'd3
  } state_t;

  localparam logic [5:0] MIN_T = 6'(MIN_GREEN - 1);
  localparam logic [5:0] MAX_T = 6'(MAX_GREEN - 1);
  localparam logic [5:0] YEL_T = 6'(YELLOW - 1);
  localparam logic [5:0] AR_T  = 6'(ALL_RED - 1);

  state_t     state, state_n;
  logic [5:0] timer, timer_n;
  logic [3:0] pend, pend_n;
  logic [1:0] phase, phase_n;
  logic [3:0] ack, ack_n;

  logic [1:0] winner;
  logic [3:0] grant;
  logic [3:0] req_lat;
  logic [3:0] other;
  logic       start_green;
  logic       exit_green;

  // Round-robin pick: scanning from the farthest offset down to phase+1 leaves the
  // nearest pending approach as the final assignment; the served phase itself ranks last.
  always_comb begin
    winner = phase + 2'd1;
    for (int k = 4; k >= 1; k--) begin
      if (pend[2'(phase + 2'(k))]) winner = 2'(phase + 2'(k));
    end
  end

  // The approach showing green does not re-queue itself from its own sensor.
  always_comb begin
    req_lat = bus.req;
    if (state == S_GREEN) req_lat[phase] = 1'b0;
  end

  assign other      = pend & ~(4'b0001 << phase);
  assign exit_green = (timer >= MIN_T) && (other != 4'b0000) &&
                      (!bus.req[phase] || (timer >= MAX_T));

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_n     = state;
    timer_n     = timer + 6'd1;
    phase_n     = phase;
    ack_n       = 4'b0000;
    grant       = 4'b0000;
    start_green = 1'b0;

    unique case (state)
      S_IDLE: start_green = |pend;
      S_GREEN: begin
        if (exit_green) begin
          state_n = S_YELLOW;
          timer_n = 6'd0;
        end else if (timer >= MAX_T) begin
          timer_n = MAX_T;
        end
      end
      S_YELLOW: begin
        if (timer == YEL_T) begin
          state_n = S_ALLRED;
          timer_n = 6'd0;
        end
      end
      S_ALLRED: begin
        if (timer == AR_T) begin
          if (|pend) begin
            start_green = 1'b1;
          end else begin
            state_n = S_IDLE;
            timer_n = 6'd0;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (start_green) begin
      state_n = S_GREEN;
      timer_n = 6'd0;
      phase_n = winner;
      grant   = 4'b0001 << winner;
      ack_n   = grant;
    end

    // A grant overrides a same-cycle request from the granted approach.
    pend_n = (pend | req_lat) & ~grant;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      timer <= 6'd0;
      pend  <= 4'b0000;
      phase <= 2'd3;
      ack   <= 4'b0000;
    end else begin
      state <= state_n;
      timer <= timer_n;
      pend  <= pend_n;
      phase <= phase_n;
      ack   <= ack_n;
    end
  end

  // Lamp decode from registered state only.
  always_comb begin
    bus.red = 4'b1111;
    bus.yel = 4'b0000;
    bus.gre = 4'b0000;
    unique case (state)
      S_GREEN: begin
        bus.gre = 4'b0001 << phase;
        bus.red = ~(4'b0001 << phase);
      end
      S_YELLOW: begin
        bus.yel = 4'b0001 << phase;
        bus.red = ~(4'b0001 << phase);
      end
      default: ;
    endcase
  end

  assign bus.ack   = ack;
  assign bus.phase = phase;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Scoreboard bench for tl_phase_scheduler: a behavioural model predicts lamps and grants
// from the phase-timing rules; a monitor compares them against the DUT every cycle.
module tb_tl_phase_scheduler;

  localparam int MIN_G = 8;
  localparam int MAX_G = 24;
  localparam int YEL_L = 4;
  localparam int AR_L  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tl_phase_if bus ();

  tl_phase_scheduler #(
    .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW(YEL_L), .ALL_RED(AR_L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] yel;
    logic [3:0] gre;
    logic [3:0] ack;
    logic [1:0] phase;
  } obs_t;

  obs_t exp_q[$];
  int   grant_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks which interval is showing and for how many cycles so far.
  typedef enum int {M_IDLE, M_GO, M_WARN, M_CLEAR} mode_t;
  mode_t      m_mode;
  int         m_len;
  int         m_last;
  logic [3:0] m_pend;
  logic [3:0] m_ack;

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_len  = 0;
    m_last = 3;
    m_pend = 4'b0000;
    m_ack  = 4'b0000;
  endfunction

  function automatic int pick();
    for (int k = 1; k <= 4; k++)
      if (m_pend[(m_last + k) % 4]) return (m_last + k) % 4;
    return 0;
  endfunction

  function automatic void model_step(input logic [3:0] r);
    logic [3:0] lat;
    logic [3:0] grant;
    logic [3:0] others;
    logic       start;
    int         w;
    lat   = r;
    grant = 4'b0000;
    start = 1'b0;
    m_ack = 4'b0000;
    if (m_mode == M_GO) lat[m_last] = 1'b0;
    case (m_mode)
      M_IDLE: start = (m_pend != 4'b0000);
      M_GO: begin
        others = m_pend & ~(4'b0001 << m_last);
        if (m_len >= MIN_G && others != 4'b0000 && (!r[m_last] || m_len >= MAX_G)) begin
          m_mode = M_WARN;
          m_len  = 1;
        end else m_len++;
      end
      M_WARN: begin
        if (m_len == YEL_L) begin
          m_mode = M_CLEAR;
          m_len  = 1;
        end else m_len++;
      end
      default: begin
        if (m_len == AR_L) begin
          if (m_pend != 4'b0000) start = 1'b1;
          else begin
            m_mode = M_IDLE;
            m_len  = 0;
          end
        end else m_len++;
      end
    endcase
    if (start) begin
      w      = pick();
      m_mode = M_GO;
      m_len  = 1;
      m_last = w;
      grant  = 4'b0001 << w;
      m_ack  = grant;
      grant_q.push_back(w);
    end
    m_pend = (m_pend | lat) & ~grant;
  endfunction

  function automatic obs_t expected();
    obs_t o;
    o.red   = 4'b1111;
    o.yel   = 4'b0000;
    o.gre   = 4'b0000;
    o.ack   = m_ack;
    o.phase = 2'(m_last);
    if (m_mode == M_GO) begin
      o.gre = 4'b0001 << m_last;
      o.red = ~o.gre;
    end else if (m_mode == M_WARN) begin
      o.yel = 4'b0001 << m_last;
      o.red = ~o.yel;
    end
    return o;
  endfunction

  // Monitor: compares each predicted cycle, and each observed grant pulse against the grant queue.
  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      obs_t e;
      e = exp_q.pop_front();
      check("red",   bus.red,   e.red);
      check("yel",   bus.yel,   e.yel);
      check("gre",   bus.gre,   e.gre);
      check("ack",   bus.ack,   e.ack);
      check("phase", bus.phase, e.phase);
      if (bus.ack != 4'b0000) begin
        if (grant_q.size() == 0) check("unexpected_grant", bus.ack, 4'b0000);
        else begin
          int w;
          w = grant_q.pop_front();
          check("grant_ack", bus.ack, 4'b0001 << w);
        end
      end
    end
  end

  int g2_cnt;

  task automatic cyc(input logic [3:0] r);
    @(negedge clk);
    if (bus.gre == 4'b0100) g2_cnt++;
    bus.req = r;
    model_step(r);
    exp_q.push_back(expected());
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(4'b0000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst     = 1'b1;
    bus.req = 4'b0000;
    #1;
    check("rst_red",   bus.red,   4'b1111);
    check("rst_yel",   bus.yel,   4'b0000);
    check("rst_gre",   bus.gre,   4'b0000);
    check("rst_ack",   bus.ack,   4'b0000);
    check("rst_phase", bus.phase, 2'd3);
    exp_q.delete();
    grant_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.req = 4'b0000;
    model_reset();
    do_reset();

    // Approach 2 green without its own demand, approach 0 arrives: 8-cycle green.
    g2_cnt = 0;
    cyc(4'b0100);
    cyc(4'b0000);
    cyc(4'b0001);
    idle_cycles(40);
    check("green2_min_len", g2_cnt, MIN_G);

    // Single request rests in green; then yellow-time re-request of approach 2 behind approach 1.
    do_reset();
    cyc(4'b0100);
    idle_cycles(20);
    cyc(4'b0010);
    cyc(4'b0000);
    cyc(4'b0100);
    idle_cycles(60);

    // Approach 2 held with approach 0 waiting: green capped at MAX.
    do_reset();
    g2_cnt = 0;
    cyc(4'b0100);
    cyc(4'b0100);
    cyc(4'b0101);
    for (int i = 0; i < 40; i++) cyc(4'b0100);
    check("green2_max_len", g2_cnt, MAX_G);
    idle_cycles(30);

    // All approaches held from reset: full rotation 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 4 * (MAX_G + YEL_L + AR_L) + 10; i++) cyc(4'b1111);
    idle_cycles(60);

    // Randomised bursts of demand.
    for (int b = 0; b < 120; b++) begin
      logic [3:0] r;
      int         len;
      r   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
      len = $urandom_range(1, 25);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 4) == 0) cyc(4'($urandom_range(0, 15)));
        else cyc(r);
      end
    end

    // Drive approach 3 into green, then assert reset mid-green.
    begin
      int n;
      n = 0;
      while (!(m_mode == M_GO && m_last == 3 && m_len >= 3) && n < 300) begin
        cyc(4'b1000);
        n++;
      end
      check("reach_green3", (m_mode == M_GO && m_last == 3) ? 1 : 0, 1);
    end
    @(negedge clk);
    #1;
    check("pre_reset_gre", bus.gre, 4'b1000);
    exp_q.delete();
    grant_q.delete();
    do_reset();
    idle_cycles(12);

    repeat (3) @(negedge clk);
    check("grant_queue_drained", grant_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
